// File: rtl/cnn_mac_pipe_if.sv
// Operand-in / result-out handshake bundle for the MAC pipeline.
// master drives beats and consumes results; slave is the MAC block.
interface cnn_mac_pipe_if #(
    parameter int DIN0_WIDTH = 9,
    parameter int DIN1_WIDTH = 11,
    parameter int ACC_WIDTH  = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIN0_WIDTH-1:0] din0;
    logic [DIN1_WIDTH-1:0] din1;
    logic                  is_signed;
    logic                  first;
    logic                  last;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_WIDTH-1:0]  dout;
    logic                  dout_ovf;

    modport master (
        output in_valid, din0, din1, is_signed, first, last, out_ready,
        input  in_ready, out_valid, dout, dout_ovf
    );

    modport slave (
        input  in_valid, din0, din1, is_signed, first, last, out_ready,
        output in_ready, out_valid, dout, dout_ovf
    );
endinterface

// File: rtl/cnn_mac_pipe.sv
// Saturating multiply-accumulate: NUM_STAGE product registers plus one accumulate stage, result NUM_STAGE+1 cycles after acceptance.
// A held, unconsumed result freezes the whole pipeline and drops in_ready; otherwise one beat per cycle.
module cnn_mac_pipe #(
    parameter int DIN0_WIDTH = 9,
    parameter int DIN1_WIDTH = 11,
    parameter int ACC_WIDTH  = 32,
    parameter int NUM_STAGE  = 2
) (
    input logic           ap_clk,
    input logic           ap_rst_n,
    cnn_mac_pipe_if.slave bus
);
    localparam int PW = DIN0_WIDTH + DIN1_WIDTH + 2;
    localparam int EW = ((ACC_WIDTH > PW) ? ACC_WIDTH : PW) + 2;
    localparam int T  = NUM_STAGE - 1;

    localparam logic signed [EW-1:0] SMAX = {{(EW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] SMIN = {{(EW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [EW-1:0] UMAX = {{(EW-ACC_WIDTH){1'b0}}, {ACC_WIDTH{1'b1}}};

    logic                 en;
    logic                 accept;
    logic                 out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0] dout_q, dout_d;
    logic                 dout_ovf_q, dout_ovf_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic                 in_mode_q;

    assign en            = !(out_valid_q && !bus.out_ready);
    assign accept        = bus.in_valid && en;
    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.dout_ovf  = dout_ovf_q;

    // Group mode is latched at the input so later beats' products use the first beat's signedness.
    logic                    sgn_in;
    logic signed [PW-1:0]    a_w, b_w, mul_prod;

    assign sgn_in   = bus.first ? bus.is_signed : in_mode_q;
    assign a_w      = {{(PW-DIN0_WIDTH){sgn_in & bus.din0[DIN0_WIDTH-1]}}, bus.din0};
    assign b_w      = {{(PW-DIN1_WIDTH){sgn_in & bus.din1[DIN1_WIDTH-1]}}, bus.din1};
    assign mul_prod = a_w * b_w;

    logic [NUM_STAGE-1:0] st_vld_q, st_first_q, st_last_q, st_sgn_q;
    logic signed [PW-1:0] st_prod_q [NUM_STAGE];

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            in_mode_q  <= 1'b0;
            st_vld_q   <= '0;
            st_first_q <= '0;
            st_last_q  <= '0;
            st_sgn_q   <= '0;
            for (int i = 0; i < NUM_STAGE; i++) st_prod_q[i] <= '0;
        end else if (en) begin
            if (accept && bus.first) in_mode_q <= bus.is_signed;
            st_vld_q[0]   <= accept;
            st_first_q[0] <= bus.first;
            st_last_q[0]  <= bus.last;
            st_sgn_q[0]   <= sgn_in;
            st_prod_q[0]  <= mul_prod;
            for (int i = 1; i < NUM_STAGE; i++) begin
                st_vld_q[i]   <= st_vld_q[i-1];
                st_first_q[i] <= st_first_q[i-1];
                st_last_q[i]  <= st_last_q[i-1];
                st_sgn_q[i]   <= st_sgn_q[i-1];
                st_prod_q[i]  <= st_prod_q[i-1];
            end
        end
    end

    logic signed [EW-1:0] acc_ext, prod_ext, base, sum;
    logic                 sat_hi, sat_lo;
    logic [ACC_WIDTH-1:0] res;

    // The sum is formed wide enough that clamping is an exact range test.
    always_comb begin
        acc_ext  = st_sgn_q[T] ? {{(EW-ACC_WIDTH){acc_q[ACC_WIDTH-1]}}, acc_q}
                               : {{(EW-ACC_WIDTH){1'b0}}, acc_q};
        prod_ext = {{(EW-PW){st_prod_q[T][PW-1]}}, st_prod_q[T]};
        base     = st_first_q[T] ? '0 : acc_ext;
        sum      = base + prod_ext;
        sat_hi   = st_sgn_q[T] ? (sum > SMAX) : (sum > UMAX);
        sat_lo   = st_sgn_q[T] && (sum < SMIN);
        if (sat_hi)      res = st_sgn_q[T] ? SMAX[ACC_WIDTH-1:0] : UMAX[ACC_WIDTH-1:0];
        else if (sat_lo) res = SMIN[ACC_WIDTH-1:0];
        else             res = sum[ACC_WIDTH-1:0];

        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        dout_d      = dout_q;
        dout_ovf_d  = dout_ovf_q;
        if (st_vld_q[T]) begin
            acc_d = res;
            ovf_d = (st_first_q[T] ? 1'b0 : ovf_q) | sat_hi | sat_lo;
            if (st_last_q[T]) begin
                out_valid_d = 1'b1;
                dout_d      = res;
                dout_ovf_d  = ovf_d;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            dout_ovf_q  <= 1'b0;
        end else if (en) begin
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            dout_ovf_q  <= dout_ovf_d;
        end
    end
endmodule

// File: tb/tb_cnn_mac_pipe.sv
// Drives one beat stream into a 32-bit and a 20-bit accumulator instance and
// scoreboards both against a behavioural saturating-MAC model.
module tb_cnn_mac_pipe;
    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    always #5 ap_clk = ~ap_clk;

    logic        in_valid = 1'b0;
    logic [8:0]  din0 = '0;
    logic [10:0] din1 = '0;
    logic        is_signed = 1'b0, first = 1'b0, last = 1'b0, out_ready = 1'b1;

    cnn_mac_pipe_if #(.DIN0_WIDTH(9), .DIN1_WIDTH(11), .ACC_WIDTH(32)) ifa ();
    cnn_mac_pipe_if #(.DIN0_WIDTH(9), .DIN1_WIDTH(11), .ACC_WIDTH(20)) ifb ();

    assign ifa.in_valid = in_valid;   assign ifb.in_valid = in_valid;
    assign ifa.din0 = din0;           assign ifb.din0 = din0;
    assign ifa.din1 = din1;           assign ifb.din1 = din1;
    assign ifa.is_signed = is_signed; assign ifb.is_signed = is_signed;
    assign ifa.first = first;         assign ifb.first = first;
    assign ifa.last = last;           assign ifb.last = last;
    assign ifa.out_ready = out_ready; assign ifb.out_ready = out_ready;

    cnn_mac_pipe #(.DIN0_WIDTH(9), .DIN1_WIDTH(11), .ACC_WIDTH(32), .NUM_STAGE(2)) u_dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(ifa.slave));
    cnn_mac_pipe #(.DIN0_WIDTH(9), .DIN1_WIDTH(11), .ACC_WIDTH(20), .NUM_STAGE(2)) u_dut20 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(ifb.slave));

    typedef struct {
        logic [63:0] d;
        logic        o;
    } exp_t;

    exp_t   qa[$], qb[$];
    exp_t   ea, eb;
    longint pop_cyc[$];
    longint cyc = 0;
    int     n_cmp = 0, n_err = 0;

    longint acc_a = 0, acc_b = 0;
    bit     ovf_a = 0, ovf_b = 0, mode_g = 0;

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input longint v, input int w);
        return ((v >> (w - 1)) & 1) != 0 ? v - (longint'(1) << w) : v;
    endfunction

    task automatic model_acc(input int w, input longint p, input bit sg, input bit f,
                             inout longint acc, inout bit ovf);
        longint base, sum, mx, mn;
        bit     sat;
        base = f ? 0 : (sg ? sx(acc, w) : acc);
        sum  = base + p;
        mx   = sg ? (longint'(1) << (w - 1)) - 1 : (longint'(1) << w) - 1;
        mn   = -(longint'(1) << (w - 1));
        sat  = (sum > mx) || (sg && sum < mn);
        if (sum > mx) sum = mx;
        else if (sg && sum < mn) sum = mn;
        acc = sum & ((longint'(1) << w) - 1);
        ovf = (f ? 1'b0 : ovf) | sat;
    endtask

    // Presents one beat, waits for the handshake, then updates the model.
    task automatic send(input int a, input int b, input bit sg, input bit f, input bit l);
        bit     rdy, me;
        int     n;
        longint am, bm, p;
        am = longint'(a) & 'h1FF;
        bm = longint'(b) & 'h7FF;
        din0 = am[8:0]; din1 = bm[10:0]; is_signed = sg; first = f; last = l;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge ap_clk);
            rdy = ifa.in_ready;
            @(posedge ap_clk);
            n++;
        end while (!rdy && n < 100);
        if (!rdy) chk("accept_timeout", rdy, 1);
        #1 in_valid = 1'b0;
        me = f ? sg : mode_g;
        mode_g = me;
        p = (me ? sx(am, 9) : am) * (me ? sx(bm, 11) : bm);
        model_acc(32, p, me, f, acc_a, ovf_a);
        model_acc(20, p, me, f, acc_b, ovf_b);
        if (l) begin
            qa.push_back('{d: acc_a, o: ovf_a});
            qb.push_back('{d: acc_b, o: ovf_b});
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
            @(posedge ap_clk);
            n++;
        end
        #1;
        chk("drain_a", qa.size(), 0);
        chk("drain_b", qb.size(), 0);
    endtask

    always @(negedge ap_clk) begin
        if (ap_rst_n && out_ready) begin
            if (ifa.out_valid) begin
                chk("a_expected", qa.size() != 0, 1);
                if (qa.size() != 0) begin
                    ea = qa.pop_front();
                    chk("a_dout", ifa.dout, ea.d);
                    chk("a_ovf", ifa.dout_ovf, ea.o);
                end
                pop_cyc.push_back(cyc);
            end
            if (ifb.out_valid) begin
                chk("b_expected", qb.size() != 0, 1);
                if (qb.size() != 0) begin
                    eb = qb.pop_front();
                    chk("b_dout", ifb.dout, eb.d);
                    chk("b_ovf", ifb.dout_ovf, eb.o);
                end
            end
        end
    end

    initial begin
        int     lat;
        longint t0;

        repeat (3) @(posedge ap_clk);
        #1;
        chk("rst_in_ready", ifa.in_ready, 1);
        chk("rst_out_valid", ifa.out_valid, 0);
        chk("rst_dout", ifa.dout, 0);
        chk("rst_ovf", ifa.dout_ovf, 0);
        chk("rst_dout20", ifb.dout, 0);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;

        // Unsigned max operands, single-beat group, latency check.
        send(511, 2047, 0, 1, 1);
        lat = 1;
        while (!ifa.out_valid && lat < 20) begin
            @(posedge ap_clk);
            #1;
            lat++;
        end
        chk("latency", lat, 3);
        drain();

        for (int i = 0; i < 4; i++) send('h1FF, 'h7FF, 1, i == 0, i == 3);
        drain();

        // Later beat's is_signed must be ignored.
        send('h1FF, 'h7FF, 1, 1, 0);
        send('h1FF, 'h7FF, 0, 0, 1);
        drain();

        for (int i = 0; i < 3; i++) send(255, 1023, 1, i == 0, i == 2);
        for (int i = 0; i < 3; i++) send(-255, 1023, 1, i == 0, i == 2);
        for (int i = 0; i < 2; i++) send(511, 2047, 0, i == 0, i == 1);
        send(255, 1023, 1, 1, 1);
        drain();

        send(3, 5, 0, 1, 1);
        send(2, 7, 0, 0, 1);
        drain();

        // Backpressure: hold a result for 5 cycles while another beat waits.
        out_ready = 1'b0;
        send(100, 200, 0, 1, 1);
        lat = 0;
        while (!ifa.out_valid && lat < 20) begin
            @(posedge ap_clk);
            #1;
            lat++;
        end
        din0 = 9'd7; din1 = 11'd9; is_signed = 1'b0; first = 1'b1; last = 1'b1;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge ap_clk);
            chk("stall_in_ready", ifa.in_ready, 0);
            chk("stall_vld", ifa.out_valid, 1);
            chk("stall_dout", ifa.dout, 20000);
        end
        @(posedge ap_clk);
        #1 out_ready = 1'b1;
        send(7, 9, 0, 1, 1);
        drain();

        // Reset with two beats in flight.
        send(10, 10, 0, 1, 0);
        send(20, 20, 0, 0, 1);
        ap_rst_n = 1'b0;
        @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        qa.delete(); qb.delete();
        acc_a = 0; acc_b = 0; ovf_a = 0; ovf_b = 0; mode_g = 0;
        repeat (6) begin
            @(negedge ap_clk);
            chk("rst_no_vld", ifa.out_valid, 0);
        end
        @(posedge ap_clk);
        #1;
        send(-3, 4, 1, 1, 0);
        send(5, -6, 1, 0, 1);
        drain();

        // Back-to-back single-beat groups at full rate.
        pop_cyc.delete();
        t0 = cyc;
        for (int i = 0; i < 8; i++) send(i + 1, 3 * i + 2, i[0], 1, 1);
        chk("b2b_accept_cycles", cyc - t0, 8);
        drain();
        chk("b2b_count", pop_cyc.size(), 8);
        if (pop_cyc.size() == 8) chk("b2b_span", pop_cyc[7] - pop_cyc[0], 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
